// File: rtl/cache_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_sdram_arbiter
// Brief    : Shares the SDRAM burst port between icache, dcache and the write
//            buffer; the write buffer always wins. Define
//            CACHE_ARB_ROUND_ROBIN_EN for round-robin between the two caches,
//            otherwise dcache has fixed priority over icache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_sdram_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_fill,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   output logic              dc_fill,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [15:0]       wb_data,
   input  logic              wb_uds_n,
   input  logic              wb_lds_n,
   output logic              wb_ack,
   output logic              sdram_req,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              sdram_rw,
   output logic [15:0]       sdram_data,
   output logic [1:0]        sdram_dqm,
   input  logic              sdram_fill,
   input  logic              sdram_wr_ack,
   output logic [1:0]        owner
);

   localparam int                  c_BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

   localparam logic [1:0] c_OWN_NONE = 2'd0;
   localparam logic [1:0] c_OWN_IC   = 2'd1;
   localparam logic [1:0] c_OWN_DC   = 2'd2;
   localparam logic [1:0] c_OWN_WB   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_STREAM  = 3'd2,
      ST_WRITE   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_BEAT_W-1:0] r_beat;
   logic                w_grant_wb;
   logic                w_grant_dc;
   logic                w_grant_ic;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // Set when dcache should win the next simultaneous cache request.
   logic r_rr_favor_dc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_favor_dc <= 1'b1;
      end else if (r_state == ST_IDLE && !wb_req && (w_grant_ic || w_grant_dc)) begin
         r_rr_favor_dc <= w_grant_ic;
      end
   end
`endif

   always_comb begin
      w_grant_wb = wb_req;
      w_grant_dc = 1'b0;
      w_grant_ic = 1'b0;
      if (!wb_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         if (dc_req && ic_req) begin
            w_grant_dc = r_rr_favor_dc;
            w_grant_ic = !r_rr_favor_dc;
         end else begin
            w_grant_dc = dc_req;
            w_grant_ic = ic_req;
         end
`else
         w_grant_dc = dc_req;
         w_grant_ic = ic_req && !dc_req;
`endif
      end
   end

   // Fill strobes are forwarded in the same cycle, only to the burst owner.
   assign ic_fill = !reset && (r_state == ST_READ) && (owner == c_OWN_IC) && sdram_fill;
   assign dc_fill = !reset && (r_state == ST_READ) && (owner == c_OWN_DC) && sdram_fill;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_beat     <= '0;
         sdram_req  <= 1'b0;
         sdram_rw   <= 1'b0;
         sdram_addr <= '0;
         sdram_data <= '0;
         sdram_dqm  <= 2'b00;
         wb_ack     <= 1'b0;
         owner      <= c_OWN_NONE;
      end else begin
         wb_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_wb) begin
                  sdram_req  <= 1'b1;
                  sdram_rw   <= 1'b0;
                  sdram_addr <= wb_addr;
                  sdram_data <= wb_data;
                  sdram_dqm  <= {wb_uds_n, wb_lds_n};
                  owner      <= c_OWN_WB;
                  r_state    <= ST_WRITE;
               end else if (w_grant_dc) begin
                  sdram_req  <= 1'b1;
                  sdram_rw   <= 1'b1;
                  sdram_addr <= dc_addr;
                  sdram_data <= 16'h0000;
                  sdram_dqm  <= 2'b00;
                  owner      <= c_OWN_DC;
                  r_state    <= ST_READ;
               end else if (w_grant_ic) begin
                  sdram_req  <= 1'b1;
                  sdram_rw   <= 1'b1;
                  sdram_addr <= ic_addr;
                  sdram_data <= 16'h0000;
                  sdram_dqm  <= 2'b00;
                  owner      <= c_OWN_IC;
                  r_state    <= ST_READ;
               end
            end
            ST_READ: begin
               if (sdram_fill) begin
                  sdram_req <= 1'b0;
                  r_beat    <= c_LAST_BEAT;
                  if (BURST_LEN > 1) begin
                     r_state <= ST_STREAM;
                  end else begin
                     owner   <= c_OWN_NONE;
                     r_state <= ST_RELEASE;
                  end
               end
            end
            ST_STREAM: begin
               // The beat that decrements to zero is the last data word.
               r_beat <= r_beat - c_BEAT_W'(1);
               if (r_beat <= c_BEAT_W'(1)) begin
                  owner   <= c_OWN_NONE;
                  r_state <= ST_RELEASE;
               end
            end
            ST_WRITE: begin
               if (sdram_wr_ack) begin
                  wb_ack    <= 1'b1;
                  sdram_req <= 1'b0;
                  owner     <= c_OWN_NONE;
                  r_state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/cache_sdram_arbiter.md
# cache_sdram_arbiter

Shares the single SDRAM burst port between the instruction cache, the data cache and the CPU write buffer. It grants one requester at a time, forwards that requester's address, direction and write data to the SDRAM controller, and routes `fill`/write-ack strobes back only to the owner. It sits between the two `TwoWayCache` instances plus the write buffer and the SDRAM controller's CPU port.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all requester and SDRAM address ports.
- `BURST_LEN`, 4, words per read burst; fill data streams on consecutive cycles starting at the `fill` strobe.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ic_req` / `dc_req` in 1: cache read-burst request; held until the cache sees its fill strobe.
- `ic_addr` / `dc_addr` in ADDR_W: burst address, already aligned to the burst (low 3 bits 0).
- `ic_fill` / `dc_fill` out 1: fill strobe routed to the owning cache.
- `wb_req` in 1: write-buffer single-word write request; held until `wb_ack`.
- `wb_addr` in ADDR_W: write address.
- `wb_data` in 16: write data.
- `wb_uds_n` / `wb_lds_n` in 1: byte-lane masks, active-low.
- `wb_ack` out 1: one-cycle write-complete pulse.
- `sdram_req` out 1: request to the controller.
- `sdram_addr` out ADDR_W: request address.
- `sdram_rw` out 1: 1 = read burst, 0 = write.
- `sdram_data` out 16: write data.
- `sdram_dqm` out 2: {upper, lower} byte masks, 1 = lane masked.
- `sdram_fill` in 1: first-word strobe of a read burst.
- `sdram_wr_ack` in 1: write-complete pulse.
- `owner` out 2: current owner; 0 = none, 1 = icache, 2 = dcache, 3 = write buffer.

## Operation
- States: IDLE, READ, STREAM, WRITE, RELEASE.
- **IDLE.** Sample the requests and pick a winner:
  - `wb_req` always wins, so no read can overtake a pending write.
  - Between the two caches, the choice is set by Configuration.
  - On a grant: latch address, rw, data and dqm into the `sdram_*` registers; set `sdram_req`=1 and set `owner`.
  - Next state is READ for a cache grant, WRITE for a write-buffer grant.
- **READ.** Hold `sdram_req` until `sdram_fill`=1. On that cycle:
  - drive `ic_fill` or `dc_fill` for the owner only, combinationally from `sdram_fill`;
  - drop `sdram_req` on the next edge;
  - load the beat counter with BURST_LEN-1;
  - go to STREAM.
- **STREAM.** Decrement the beat counter each cycle. At 0, go to RELEASE. `data_from_sdram` is wired directly to both caches and is not muxed here.
- **WRITE.** Hold `sdram_req` until `sdram_wr_ack`=1. Then pulse `wb_ack`, clear `sdram_req` and go to RELEASE.
- **RELEASE.** One cycle with `owner`=0. This lets the old owner's request fall before the next arbitration, because write-buffer requests are only seen falling one cycle after `wb_ack`. Then go to IDLE.
- A fill strobe or write ack arriving in any state other than READ or WRITE respectively is ignored: no fill or ack is forwarded.
- A requester that drops its request mid-grant does not abort the grant. The transaction still completes, because the SDRAM controller has already accepted it.
- `reset` at any time:
  - state = IDLE, and `sdram_req`, `sdram_rw`, `sdram_addr`, `sdram_data`, `sdram_dqm`, `ic_fill`, `dc_fill`, `wb_ack` and `owner` are all 0;
  - the round-robin pointer is set to favour dcache;
  - the SDRAM controller is reset by the same signal, so no in-flight burst survives.

## Timing
- Arbitration latency: a request present in IDLE on cycle N gives `sdram_req`=1 and a valid address on cycle N+1.
- Fill forwarding is zero-latency: `ic_fill`/`dc_fill` is asserted in the same cycle as `sdram_fill`.
- Read-burst occupancy: fill cycle + (BURST_LEN-1) STREAM cycles + 1 RELEASE cycle. The earliest next grant is RELEASE+1.
- `wb_ack` is exactly one cycle, registered, asserted the cycle after `sdram_wr_ack`.
- All `sdram_*` outputs are registered and stable while `sdram_req`=1.

## Configuration
- Macro `CACHE_ARB_ROUND_ROBIN_EN`.
- Defined:
  - when both caches request in IDLE, the grant goes to the one not served by the most recent cache grant;
  - the pointer updates only on cache grants, not write grants.
- Undefined: fixed priority, dcache over icache; the pointer logic is absent.
- The write buffer has top priority in both builds.

## Test plan
- Reset mid-STREAM: `reset`=1 for 1 cycle during beat 2 -> all outputs 0 and `owner`=0 next cycle; a subsequent `ic_req` is granted normally.
- Single icache read: `ic_req`=1, `ic_addr`=0x00123450 -> next cycle `sdram_req`=1, `sdram_rw`=1, `sdram_addr`=0x00123450, `owner`=1. `sdram_fill` 3 cycles later -> `ic_fill`=1 in the same cycle and `dc_fill`=0. `owner`=0 exactly 4 cycles after the fill, and the next grant is 1 cycle later.
- Write priority: `wb_req`, `dc_req` and `ic_req` rise on the same cycle, with `wb_lds_n`=0, `wb_uds_n`=1 and `wb_data`=0xBEEF -> write granted first with `sdram_rw`=0, `sdram_dqm`=2'b10 and `sdram_data`=0xBEEF. `wb_ack` is a single pulse the cycle after `sdram_wr_ack`. dcache is granted after RELEASE.
- Cache contention: `ic_req` and `dc_req` held high continuously for 4 bursts -> with the macro, grants go dc, ic, dc, ic; without it, dc on every burst while `dc_req` is held.
- Stray strobes: `sdram_fill`=1 while `owner`=3, and `sdram_wr_ack`=1 in IDLE -> no `ic_fill`, `dc_fill` or `wb_ack`, and no state change.
